// File: rtl/pid_steer_ctrl_pkg.sv
// Shared constants, term widths and the saturation helper for the steering PID.
// Used by pid_steer_ctrl and pid_integrator.
package pid_pkg;

  localparam logic signed [5:0] P_COEFF_DEF = 6'sh10;
  localparam logic signed [4:0] D_COEFF_DEF = 5'sh07;

  localparam int ERR_W     = 12;
  localparam int FRWRD_W   = 10;
  localparam int ESAT_W    = 10;
  localparam int INTEG_W   = 15;
  localparam int DSAT_W    = 7;
  localparam int SUM_W     = 16;
  localparam int SPD_W     = 11;
  localparam int I_SHIFT   = 6;
  localparam int PID_SHIFT = 3;

  typedef logic signed [SUM_W-1:0] sum_t;

  // Clamp a 16-bit signed value into the w-bit signed range (result kept 16-bit wide).
  function automatic sum_t sat_signed(input sum_t v, input int w);
    sum_t hi;
    sum_t lo;
    hi = sum_t'((32'sd1 <<< (w - 1)) - 1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_steer_ctrl_if.sv
// Heading-error in / motor-speed out bundle for pid_steer_ctrl.
// master = error source side, slave = the controller.
interface pid_steer_ctrl_if;
  logic                                 moving;
  logic                                 err_vld;
  logic signed [pid_pkg::ERR_W-1:0]     error;
  logic        [pid_pkg::FRWRD_W-1:0]   frwrd;
  logic signed [pid_pkg::SPD_W-1:0]     lft_spd;
  logic signed [pid_pkg::SPD_W-1:0]     rght_spd;

  modport master (
    output moving, err_vld, error, frwrd,
    input  lft_spd, rght_spd
  );

  modport slave (
    input  moving, err_vld, error, frwrd,
    output lft_spd, rght_spd
  );
endinterface

// File: rtl/pid_steer_ctrl_integrator.sv
// pid_integrator: 15-bit signed accumulator of the saturated error.
// Holds on signed overflow instead of wrapping; cleared whenever the robot stops.
module pid_integrator
  import pid_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      moving,
  input  logic                      err_vld,
  input  logic signed [ESAT_W-1:0]  err_sat,
  output logic signed [INTEG_W-1:0] integ
);

  logic signed [INTEG_W-1:0] integ_q;
  logic signed [INTEG_W-1:0] integ_d;
  logic signed [INTEG_W-1:0] addend;
  logic signed [INTEG_W-1:0] nxt;
  logic                      ovf;

  always_comb begin
    addend  = {{(INTEG_W-ESAT_W){err_sat[ESAT_W-1]}}, err_sat};
    nxt     = integ_q + addend;
    ovf     = (integ_q[INTEG_W-1] == addend[INTEG_W-1]) &&
              (nxt[INTEG_W-1] != integ_q[INTEG_W-1]);
    integ_d = integ_q;
    if (!moving) begin
      integ_d = '0;
    end else if (err_vld && !ovf) begin
      integ_d = nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q <= '0;
    end else begin
      integ_q <= integ_d;
    end
  end

  assign integ = integ_q;

endmodule

// File: rtl/pid_steer_ctrl.sv
// Steering PID: heading error -> left/right motor speeds around a forward base speed.
// Define PID_D_TERM_EN to build the derivative path; without it D_term is zero.
module pid_steer_ctrl
  import pid_pkg::*;
#(
  parameter logic signed [5:0] P_COEFF = P_COEFF_DEF,
  parameter logic signed [4:0] D_COEFF = D_COEFF_DEF
)(
  input  logic              clk,
  input  logic              rst,
  pid_steer_ctrl_if.slave   bus
);

  logic signed [ESAT_W-1:0]  err_sat;
  logic signed [INTEG_W-1:0] integ;
  logic signed [SPD_W-1:0]   lft_sat;
  logic signed [SPD_W-1:0]   rght_sat;
  sum_t err_ext;
  sum_t err_sat_ext;
  sum_t p_term;
  sum_t i_term;
  sum_t d_term;
  sum_t pid_sum;
  sum_t pid;
  sum_t frwrd_ext;
  sum_t lft_raw;
  sum_t rght_raw;

  pid_integrator u_integrator (
    .clk     (clk),
    .rst     (rst),
    .moving  (bus.moving),
    .err_vld (bus.err_vld),
    .err_sat (err_sat),
    .integ   (integ)
  );

  // All terms are sign-extended to 16 bits first so the sum never wraps.
  always_comb begin
    err_ext     = {{(SUM_W-ERR_W){bus.error[ERR_W-1]}}, bus.error};
    err_sat     = ESAT_W'(sat_signed(err_ext, ESAT_W));
    err_sat_ext = {{(SUM_W-ESAT_W){err_sat[ESAT_W-1]}}, err_sat};
    p_term      = err_sat_ext * {{(SUM_W-6){P_COEFF[5]}}, P_COEFF};
    i_term      = sum_t'({{(SUM_W-INTEG_W){integ[INTEG_W-1]}}, integ}) >>> I_SHIFT;
    pid_sum     = p_term + i_term + d_term;
    pid         = pid_sum >>> PID_SHIFT;
    frwrd_ext   = {{(SUM_W-FRWRD_W){1'b0}}, bus.frwrd};
    lft_raw     = frwrd_ext + pid;
    rght_raw    = frwrd_ext - pid;
    lft_sat     = SPD_W'(sat_signed(lft_raw, SPD_W));
    rght_sat    = SPD_W'(sat_signed(rght_raw, SPD_W));
  end

`ifdef PID_D_TERM_EN
  logic signed [ESAT_W-1:0] prev_err_q;
  logic signed [ESAT_W-1:0] prev_err_d;
  logic signed [DSAT_W-1:0] d_sat;
  sum_t prev_ext;
  sum_t d_diff;

  always_comb begin
    prev_err_d = bus.err_vld ? err_sat : prev_err_q;
    prev_ext   = {{(SUM_W-ESAT_W){prev_err_q[ESAT_W-1]}}, prev_err_q};
    d_diff     = err_sat_ext - prev_ext;
    d_sat      = DSAT_W'(sat_signed(d_diff, DSAT_W));
    d_term     = {{(SUM_W-DSAT_W){d_sat[DSAT_W-1]}}, d_sat} *
                 {{(SUM_W-5){D_COEFF[4]}}, D_COEFF};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_err_q <= '0;
    end else begin
      prev_err_q <= prev_err_d;
    end
  end
`else
  assign d_term = '0;
`endif

  assign bus.lft_spd  = bus.moving ? lft_sat  : '0;
  assign bus.rght_spd = bus.moving ? rght_sat : '0;

endmodule

// File: tb/tb_pid_steer_ctrl.sv
// Self-checking bench for pid_steer_ctrl: directed cases plus randomized traffic
// compared every cycle against an arithmetic model of the steering law.
module tb_pid_steer_ctrl;

`ifdef PID_D_TERM_EN
  localparam bit D_EN = 1'b1;
`else
  localparam bit D_EN = 1'b0;
`endif

  localparam logic [10:0] C2_L = D_EN ? 11'h12E : 11'h120;
  localparam logic [10:0] C2_R = D_EN ? 11'h0D2 : 11'h0E0;
  localparam logic [10:0] C3_L = D_EN ? 11'h3FF : 11'h3FE;
  localparam logic [10:0] C3_R = D_EN ? 11'h400 : 11'h402;
  localparam logic [10:0] C7_R = D_EN ? 11'h7CA : 11'h001;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_integ  = 0;
  int   m_prev   = 0;

  pid_steer_ctrl_if bus ();

  pid_steer_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int floor_div(input int v, input int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int cur_err_sat();
    return clamp(int'(bus.error), -512, 511);
  endfunction

  function automatic int model_pid();
    int es;
    int d;
    es = cur_err_sat();
    d  = 0;
    if (D_EN) d = clamp(es - m_prev, -64, 63) * 7;
    return floor_div(es * 16 + floor_div(m_integ, 64) + d, 8);
  endfunction

  function automatic logic [10:0] model_spd(input bit left);
    int s;
    if (!bus.moving) return 11'h000;
    s = left ? int'(bus.frwrd) + model_pid() : int'(bus.frwrd) - model_pid();
    return 11'(clamp(s, -1024, 1023));
  endfunction

  // Model state: integrator stays inside the 15-bit range, otherwise it holds.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_integ <= 0;
      m_prev  <= 0;
    end else begin
      if (!bus.moving) begin
        m_integ <= 0;
      end else if (bus.err_vld && (m_integ + cur_err_sat() <= 16383) &&
                   (m_integ + cur_err_sat() >= -16384)) begin
        m_integ <= m_integ + cur_err_sat();
      end
      if (bus.err_vld) m_prev <= cur_err_sat();
    end
  end

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%03h expected 0x%03h", name, got, exp);
  endtask

  task automatic lit(input string name, input logic [10:0] exp_l, input logic [10:0] exp_r);
    check({name, "_lft"}, bus.lft_spd, exp_l);
    check({name, "_rght"}, bus.rght_spd, exp_r);
    check({name, "_model_lft"}, model_spd(1'b1), exp_l);
    check({name, "_model_rght"}, model_spd(1'b0), exp_r);
    $display("case %s: lft=0x%03h rght=0x%03h", name, bus.lft_spd, bus.rght_spd);
  endtask

  always @(negedge clk) begin
    check("cyc_lft", bus.lft_spd, model_spd(1'b1));
    check("cyc_rght", bus.rght_spd, model_spd(1'b0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    int mode;
    rst         = 1'b1;
    bus.moving  = 1'b0;
    bus.err_vld = 1'b0;
    bus.error   = 12'h7FF;
    bus.frwrd   = 10'h3FF;
    #2 lit("c1_stopped", 11'h000, 11'h000);
    tick();
    tick();
    rst = 1'b0;

    rst_pulse();
    bus.moving = 1'b1; bus.err_vld = 1'b0; bus.error = 12'h010; bus.frwrd = 10'h100;
    #1 lit("c2_small_err", C2_L, C2_R);

    rst_pulse();
    bus.error = 12'h7FF; bus.frwrd = 10'h000;
    #1 lit("c3_saturate", C3_L, C3_R);

    rst_pulse();
    bus.err_vld = 1'b1; bus.error = 12'h040; bus.frwrd = 10'h000;
    repeat (4) tick();
    bus.err_vld = 1'b0;
    #1 lit("c4_integrate", 11'h080, 11'h780);

    bus.moving = 1'b0;
    #1 lit("c5_idle", 11'h000, 11'h000);
    tick();
    bus.moving = 1'b1;
    #1 lit("c5_cleared", 11'h080, 11'h780);

    rst_pulse();
    bus.err_vld = 1'b1; bus.error = 12'h1FF; bus.frwrd = 10'h3FF;
    repeat (40) tick();
    bus.err_vld = 1'b0;
    #1 lit("c6_pos_ovf_hold", 11'h3FF, 11'h7E2);

    // Asynchronous reset must clear state without waiting for a clock edge.
    #1 rst = 1'b1;
    #1 lit("c7_async_rst", 11'h3FF, C7_R);
    tick();
    rst = 1'b0;

    rst_pulse();
    bus.err_vld = 1'b1; bus.error = 12'hE00; bus.frwrd = 10'h3FF;
    repeat (40) tick();
    bus.err_vld = 1'b0;
    #1 lit("c6b_neg_ovf_hold", 11'h7DF, 11'h3FF);

    for (int blk = 0; blk < 16; blk++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 200; i++) begin
        tick();
        rst         = ($urandom_range(0, 399) == 0);
        bus.moving  = ($urandom_range(0, 63) != 0);
        bus.err_vld = ($urandom_range(0, 3) != 0);
        bus.frwrd   = 10'($urandom);
        case (mode)
          0:       bus.error = 12'($urandom);
          1:       bus.error = 12'($urandom_range(0, 160) - 80);
          2:       bus.error = 12'($urandom_range(300, 2047));
          default: bus.error = 12'(-$urandom_range(300, 2048));
        endcase
      end
    end
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
